m24c16_xfer_seq: RTL

Transaction sequencer for M24Cxx I2C EEPROMs, sitting directly upstream of the I2C byte engine. It accepts one page-write or sequential-read request and breaks it into byte-level engine operations: device select, word address, data bytes, repeated start, and stop. It also buffers host write data in a 16-byte FIFO and performs post-write ACK polling, so the host never issues per-byte commands.

---
 rtl/m24c16_pkg.sv | 10 +
 rtl/m24c16_wfifo.sv | 44 ++++
 rtl/m24c16_xfer_seq.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/m24c16_pkg.sv
// m24c16_pkg: shared states, result codes and constants for the M24Cxx transaction sequencer
package m24c16_pkg;
    typedef enum logic [3:0] {IDLE, DEVSEL_W, ADDR, WDATA, DEVSEL_R, RDATA, POLL, ABORT, DONE} state_t;
    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_NACK = 2'd1;
    localparam logic [1:0] ERR_POLL = 2'd2;
    localparam logic [1:0] ERR_BAD  = 2'd3;
    localparam logic [3:0] DEVSEL_PREFIX = 4'b1010;
    localparam int PAGE_SIZE = 16;
endpackage

// File: rtl/m24c16_wfifo.sv
// m24c16_wfifo: 16x8 write-data FIFO with occupancy count and synchronous flush
//   push/din in, pop/dout out (dout shows head), full and count (0..16) status
module m24c16_wfifo
    import m24c16_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       flush,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic [4:0] count
);
    logic [7:0] mem_q [PAGE_SIZE];
    logic [3:0] wp_q, wp_d, rp_q, rp_d;
    logic [4:0] count_q, count_d;
    logic       push_ok, pop_ok;
    always_comb begin
        push_ok = push & !full & !flush;
        pop_ok  = pop & (count_q != 5'd0) & !flush;
        wp_d    = flush ? 4'd0 : wp_q + {3'b0, push_ok};
        rp_d    = flush ? 4'd0 : rp_q + {3'b0, pop_ok};
        count_d = flush ? 5'd0 : count_q + {4'b0, push_ok} - {4'b0, pop_ok};
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wp_q] <= din;
    end
    assign dout  = mem_q[rp_q];
    assign full  = count_q == 5'(PAGE_SIZE);
    assign count = count_q;
endmodule

// File: rtl/m24c16_xfer_seq.sv
// m24c16_xfer_seq: splits one page-write or sequential-read request into I2C byte-engine ops
//   req_*: host request; wr_*: write FIFO; rd_*: read byte handshake; busy/done/err: status
//   eng_*: byte-engine op strobe, byte, qualifiers and completion/response
module m24c16_xfer_seq
    import m24c16_pkg::*;
#(
    parameter int POLL_MAX = 255
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [2:0] req_dev,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_len,
    input  logic [7:0] wr_data,
    input  logic       wr_push,
    output logic       wr_full,
    output logic [4:0] wr_count,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic       busy,
    output logic       done,
    output logic [1:0] err,
    output logic       eng_start,
    output logic [7:0] eng_tx,
    output logic       eng_read,
    output logic       eng_gen_start,
    output logic       eng_gen_stop,
    output logic       eng_nobyte,
    output logic       eng_ack_out,
    input  logic       eng_done,
    input  logic [7:0] eng_rx,
    input  logic       eng_nack
);
    state_t      state_q, state_d;
    logic [2:0]  dev_q, dev_d;
    logic [7:0]  addr_q, addr_d, cnt_q, cnt_d, rd_data_q, rd_data_d;
    logic        write_q, write_d, rd_valid_q, rd_valid_d, pend_q, pend_d;
    logic [15:0] poll_q, poll_d;
    logic [1:0]  err_q, err_d;
    logic [7:0]  eng_tx_q, eng_tx_d;
    logic        eng_read_q, eng_read_d, eng_gen_start_q, eng_gen_start_d;
    logic        eng_gen_stop_q, eng_gen_stop_d, eng_nobyte_q, eng_nobyte_d;
    logic        eng_ack_out_q, eng_ack_out_d;
    logic        enter, flush, bad, last_d, stall;
    logic [7:0]  fifo_dout;
    m24c16_wfifo u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (wr_push),
        .din     (wr_data),
        .pop     (eng_start && state_q == WDATA),
        .dout    (fifo_dout),
        .full    (wr_full),
        .count   (wr_count)
    );
    // A page write must fit inside one page and be fully buffered before any bus activity.
    assign bad = req_write & (({1'b0, req_len} > 9'(PAGE_SIZE - 1))
                 | ({5'b0, req_addr[3:0]} + {1'b0, req_len} > 9'(PAGE_SIZE - 1))
                 | ({4'b0, wr_count} < {1'b0, req_len} + 9'd1));
    assign stall = state_q == RDATA && rd_valid_q && !rd_ready;
    always_comb begin
        state_d    = state_q;
        dev_d      = dev_q;
        addr_d     = addr_q;
        write_d    = write_q;
        cnt_d      = cnt_q;
        poll_d     = poll_q;
        err_d      = err_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q & !rd_ready;
        enter      = 1'b0;
        flush      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (req_valid) begin
                    dev_d   = req_dev;
                    addr_d  = req_addr;
                    write_d = req_write;
                    cnt_d   = req_len;
                    poll_d  = '0;
                    err_d   = bad ? ERR_BAD : ERR_OK;
                    state_d = bad ? DONE : DEVSEL_W;
                    enter   = !bad;
                end
            end
            default: if (eng_done) begin
                case (state_q)
                    DEVSEL_W: state_d = eng_nack ? ABORT : ADDR;
                    ADDR:     state_d = eng_nack ? ABORT : write_q ? WDATA : DEVSEL_R;
                    DEVSEL_R: state_d = eng_nack ? ABORT : RDATA;
                    WDATA: begin
                        state_d = eng_nack ? ABORT : cnt_q == 8'd0 ? POLL : WDATA;
                        cnt_d   = cnt_q - 8'd1;
                    end
                    RDATA: begin
                        rd_data_d  = eng_rx;
                        rd_valid_d = 1'b1;
                        cnt_d      = cnt_q - 8'd1;
                        state_d    = cnt_q == 8'd0 ? DONE : RDATA;
                    end
                    POLL: begin
                        poll_d  = poll_q + 16'd1;
                        state_d = (!eng_nack || poll_d == 16'(POLL_MAX)) ? DONE : POLL;
                        err_d   = !eng_nack ? ERR_OK : poll_d == 16'(POLL_MAX) ? ERR_POLL : err_q;
                    end
                    ABORT: begin
                        state_d = DONE;
                        err_d   = ERR_NACK;
                        flush   = 1'b1;
                    end
                    default: state_d = IDLE;
                endcase
                enter = state_d != DONE;
            end
        endcase
    end
    // Op qualifiers are captured on state entry so they stay put while the engine works;
    // the WDATA byte is taken from the FIFO head before its pop at eng_start.
    always_comb begin
        last_d          = cnt_d == 8'd0;
        eng_tx_d        = !enter ? eng_tx_q
                        : state_d == ADDR     ? addr_d
                        : state_d == WDATA    ? fifo_dout
                        : state_d == DEVSEL_R ? {DEVSEL_PREFIX, dev_d, 1'b1}
                        : state_d inside {DEVSEL_W, POLL} ? {DEVSEL_PREFIX, dev_d, 1'b0}
                        : 8'h00;
        eng_read_d      = enter ? state_d == RDATA : eng_read_q;
        eng_gen_start_d = enter ? state_d inside {DEVSEL_W, DEVSEL_R, POLL} : eng_gen_start_q;
        eng_gen_stop_d  = enter ? (state_d inside {POLL, ABORT} || (state_d inside {WDATA, RDATA} && last_d))
                                : eng_gen_stop_q;
        eng_nobyte_d    = enter ? state_d == ABORT : eng_nobyte_q;
        eng_ack_out_d   = enter ? state_d == RDATA && !last_d : eng_ack_out_q;
        pend_d          = enter | (pend_q & !eng_start);
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            dev_q           <= '0;
            addr_q          <= '0;
            write_q         <= 1'b0;
            cnt_q           <= '0;
            poll_q          <= '0;
            err_q           <= ERR_OK;
            rd_data_q       <= '0;
            rd_valid_q      <= 1'b0;
            pend_q          <= 1'b0;
            eng_tx_q        <= '0;
            eng_read_q      <= 1'b0;
            eng_gen_start_q <= 1'b0;
            eng_gen_stop_q  <= 1'b0;
            eng_nobyte_q    <= 1'b0;
            eng_ack_out_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            dev_q           <= dev_d;
            addr_q          <= addr_d;
            write_q         <= write_d;
            cnt_q           <= cnt_d;
            poll_q          <= poll_d;
            err_q           <= err_d;
            rd_data_q       <= rd_data_d;
            rd_valid_q      <= rd_valid_d;
            pend_q          <= pend_d;
            eng_tx_q        <= eng_tx_d;
            eng_read_q      <= eng_read_d;
            eng_gen_start_q <= eng_gen_start_d;
            eng_gen_stop_q  <= eng_gen_stop_d;
            eng_nobyte_q    <= eng_nobyte_d;
            eng_ack_out_q   <= eng_ack_out_d;
        end
    end
    assign req_ready     = state_q == IDLE || state_q == DONE;
    assign busy          = !req_ready;
    assign done          = state_q == DONE;
    assign err           = err_q;
    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign eng_start     = pend_q & !stall;
    assign eng_tx        = eng_tx_q;
    assign eng_read      = eng_read_q;
    assign eng_gen_start = eng_gen_start_q;
    assign eng_gen_stop  = eng_gen_stop_q;
    assign eng_nobyte    = eng_nobyte_q;
    assign eng_ack_out   = eng_ack_out_q;
endmodule
